// File: rtl/ascii_digit_streamer.sv
// ascii_digit_streamer
// Snapshots four ASCII digit bytes plus an overflow flag on a start pulse and
// streams them MSD first over a valid/ready byte interface, ending each frame
// with an optional CR and a terminator byte.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle frame request, honoured only when idle
//   overflow_in counter overflow flag, captured with the digits
//   value3..0   ASCII digits, value3 most significant
//   out_data    current byte, held until accepted
//   out_valid   out_data holds a byte
//   out_ready   sink accepts the byte on an edge with out_valid high
//   busy        frame in progress
//   missed      one-cycle pulse for a start that arrived while not idle
`timescale 1ns/1ps

module ascii_digit_streamer #(
  parameter bit         SUPPRESS_ZEROS = 1'b0,
  parameter bit         EMIT_CR        = 1'b1,
  parameter logic [7:0] TERM_BYTE      = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       overflow_in,
  input  logic [7:0] value3,
  input  logic [7:0] value2,
  input  logic [7:0] value1,
  input  logic [7:0] value0,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       missed
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_NINE = 8'h39;
  localparam logic [BYTE_W-1:0] ASCII_BANG = 8'h21;
  localparam logic [BYTE_W-1:0] ASCII_QM   = 8'h3F;
  localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG  = 3'd1,
    DIGIT = 3'd2,
    CR    = 3'd3,
    TERM  = 3'd4
  } state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx, idx_nxt;
  logic [3:0][BYTE_W-1:0]      dig, dig_nxt;
  logic                        ovf, ovf_nxt;
  logic                        fire;
  logic [BYTE_W-1:0]           data_nxt;
  logic                        valid_nxt;
  logic                        missed_nxt;

  // Highest non-'0' position among 3..1; position 0 is always sent.
  function automatic logic [IDX_W-1:0] first_idx(input logic [3:0][BYTE_W-1:0] d);
    first_idx = IDX_W'(0);
    if (d[1] != ASCII_ZERO) first_idx = IDX_W'(1);
    if (d[2] != ASCII_ZERO) first_idx = IDX_W'(2);
    if (d[3] != ASCII_ZERO) first_idx = IDX_W'(3);
  endfunction

  // Anything outside '0'..'9' is shown as '?'.
  function automatic logic [BYTE_W-1:0] sanitize(input logic [BYTE_W-1:0] b);
    sanitize = (b >= ASCII_ZERO && b <= ASCII_NINE) ? b : ASCII_QM;
  endfunction

  assign fire = out_valid & out_ready;

  // State and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= IDX_W'(3);
      dig   <= {4{ASCII_ZERO}};
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dig   <= dig_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state logic; the snapshot is taken only when a frame is accepted.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dig_nxt   = dig;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          dig_nxt = {value3, value2, value1, value0};
          ovf_nxt = overflow_in;
          idx_nxt = SUPPRESS_ZEROS ? first_idx(dig_nxt) : IDX_W'(3);
          if (ovf_nxt) state_nxt = FLAG;
          else         state_nxt = DIGIT;
        end
      end
      FLAG: if (fire) state_nxt = DIGIT;
      DIGIT: begin
        if (fire) begin
          if (idx == IDX_W'(0)) begin
            if (EMIT_CR) state_nxt = CR;
            else         state_nxt = TERM;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
      CR:      if (fire) state_nxt = TERM;
      TERM:    if (fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // byte lands on the same edge the state advances.
  always_comb begin
    data_nxt   = 8'h00;
    valid_nxt  = (state_nxt != IDLE);
    missed_nxt = start & (state != IDLE);
    case (state_nxt)
      FLAG:    data_nxt = ASCII_BANG;
      DIGIT:   data_nxt = sanitize(dig_nxt[idx_nxt]);
      CR:      data_nxt = ASCII_CR;
      TERM:    data_nxt = TERM_BYTE;
      default: data_nxt = 8'h00;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      busy      <= valid_nxt;
      missed    <= missed_nxt;
    end
  end

endmodule

// File: doc/ascii_digit_streamer.md
# ascii_digit_streamer

Downstream consumer of the 4-digit ASCII decimal counter: on a `start` pulse it snapshots the four ASCII digit bytes and the overflow flag, then emits them most-significant digit first as a byte stream over a valid/ready handshake, followed by a line terminator. It sits between the counter and a byte sink such as a UART transmitter or a character display writer. It performs optional leading-zero suppression, and it sanitises out-of-range digit bytes.

## Interface
- `SUPPRESS_ZEROS`, default 0: when 1, leading `'0'` digits of value3..value1 are skipped; value0 is always sent.
- `EMIT_CR`, default 1: when 1, byte 0x0D is sent before the line feed.
- `TERM_BYTE`, default 8'h0A: final byte of every frame.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset is asynchronous and active-high.
- `start`  in  1  1-cycle request to send one frame; sampled only in IDLE.
- `overflow_in`  in  1  counter overflow flag; captured with the digits.
- `value3`..`value0`  in  8 each  ASCII digits; value3 is the most significant digit.
- `out_data`  out  8  current byte; stable while `out_valid` is high and the byte has not been accepted.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  sink accepts the byte; a transfer occurs on a clock edge where `out_valid && out_ready`.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after the last byte transfers.
- `missed`  out  1  1-cycle pulse when `start` arrives while not in IDLE.

## Operation
- States: IDLE, FLAG, DIGIT, CR, TERM.
- Reset, any time, including mid-frame:
  - state IDLE; `out_valid` 0; `out_data` 0x00; `busy` 0; `missed` 0.
  - Latched digits 0x30; latched overflow 0; digit index 3.
  - An in-flight byte is dropped with no partial completion.
- IDLE, with `start`=1:
  - Latch value3..value0 and `overflow_in`.
  - Next state is FLAG if the latched overflow is 1, otherwise DIGIT.
  - With `SUPPRESS_ZEROS`=1, the starting index is the highest i in 3..1 whose latched byte is not 0x30; if there is none, the index is 0.
- FLAG: emit 0x21 (`'!'`), then go to DIGIT.
- DIGIT: emit the latched digit at the current index.
  - Any byte outside 0x30–0x39 is emitted as 0x3F (`'?'`).
  - A non-digit byte is never treated as a leading zero.
  - At index 0, go to CR if `EMIT_CR`=1, otherwise to TERM; at other indices, decrement the index.
- CR: emit 0x0D, then go to TERM.
- TERM: emit `TERM_BYTE`, then go to IDLE.
- Input changes after the latch do not affect the frame in flight.
- Frame lengths:
  - Minimum: 2 bytes (suppression on, digits "0000", no overflow, `EMIT_CR`=0).
  - Maximum: 7 bytes (overflow, 4 digits, CR, LF).

## Timing
- `start` sampled at edge N:
  - `out_valid`=1 and `busy`=1 from cycle N+1, with the first byte on `out_data`.
  - No byte is emitted in the same cycle as `start`.
- Each state presents exactly one byte and advances on the edge where the transfer occurs.
- The next byte appears in the following cycle with `out_valid` kept high, so streaming runs at 1 byte/cycle when `out_ready` is held high.
- With `out_ready` low, `out_valid` and `out_data` hold unchanged indefinitely. `out_valid` is never withdrawn before a transfer.
- After the TERM transfer at edge M: `out_valid`=0 and `busy`=0 in cycle M+1.
- A `start` sampled at edge M+1 or later is accepted.
- A `start` at edge M itself is ignored and pulses `missed` (state is not yet IDLE).
- Frame of k bytes with `out_ready` held 1: `busy` high for exactly k cycles.
- `missed` is registered: high for the cycle after each offending `start` edge. Back-to-back offending starts give back-to-back pulses.

## Test plan
- Reset, then `start` with digits "1234", no overflow, `out_ready`=1, defaults:
  - Bytes 0x31 0x32 0x33 0x34 0x0D 0x0A on 6 consecutive cycles starting 1 cycle after `start`.
  - `busy` high for 6 cycles.
- `overflow_in`=1, digits "0007", `SUPPRESS_ZEROS`=1, `EMIT_CR`=0:
  - Bytes 0x21 0x37 0x0A.
  - Digits "0000" with the same settings give 0x30 0x0A.
- Backpressure, "9876":
  - Drop `out_ready` for 3 cycles on the second byte; `out_data` is held at 0x38 with `out_valid` high throughout.
  - The full sequence completes unaltered.
  - Change value inputs to "5555" mid-frame; the output still reads 9876.
- `start` pulses during an active frame and on the final-transfer edge:
  - Each produces a 1-cycle `missed` pulse.
  - The frame is unchanged; the next `start` after `busy` falls is accepted.
- Assert `rst` asynchronously while the third byte is pending:
  - `out_valid`, `busy` and `missed` go to 0 immediately, without waiting for a clock edge.
  - After release, a new `start` emits a complete, correct frame.
- Digit byte 0x41 at value2 → emitted as 0x3F. With suppression on, value3=0x30, value2=0x41 → frame starts at 0x3F.
